// File: rtl/lc3_mem_pkg.sv
// -----------------------------------------------------------------------------
// lc3_mem_pkg
// Shared definitions for the LC-3 memory controller:
//   - mem_state_e : controller state encoding (ERR exists only when the
//                   LC3_MEM_TIMEOUT_EN macro is defined)
//   - LD_MEMOUT / LD_BUS : LDMDR control encodings
//   - ERR_DATA    : value placed in MDR when a read times out
//   - TIMER_W     : width of the wait-timeout counter
// -----------------------------------------------------------------------------
package lc3_mem_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      DONE = 3'd3
`ifdef LC3_MEM_TIMEOUT_EN
      ,
      ERR  = 3'd4
`endif
   } mem_state_e;

   // LDMDR[1] = load MDR, LDMDR[0] = source (0: memory, 1: BUS_IN)
   localparam logic [1:0] LD_MEMOUT = 2'b10;
   localparam logic [1:0] LD_BUS    = 2'b11;

   localparam logic [15:0] ERR_DATA = 16'hDEAD;

   // Wide enough for the full WAIT_TIMEOUT range 1..255
   localparam int unsigned TIMER_W = 8;

endpackage : lc3_mem_pkg

// File: rtl/lc3_mem_timer.sv
// -----------------------------------------------------------------------------
// lc3_mem_timer
// Wait-timeout counter for one memory access. Only instantiated when the
// LC3_MEM_TIMEOUT_EN macro is defined.
//
// The count starts when the controller launches an access (start_i, seen in
// the IDLE cycle) so that the first RD/WR cycle carries count 1. expired_o is
// raised during the WAIT_TIMEOUT-th wait cycle if MEM_ACK is not present in
// that same cycle, so a late-but-in-time ack always wins.
//
// Ports
//   CLK        in   rising-edge clock
//   RESET      in   asynchronous, active-high reset
//   start_i    in   access launched this cycle
//   ack_i      in   MEM_ACK from the memory
//   expired_o  out  wait limit reached without ack (combinational)
// -----------------------------------------------------------------------------
module lc3_mem_timer
   import lc3_mem_pkg::*;
#(
   parameter int unsigned WAIT_TIMEOUT = 15
) (
   input  logic CLK,
   input  logic RESET,
   input  logic start_i,
   input  logic ack_i,
   output logic expired_o
);

   localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(WAIT_TIMEOUT);

   logic               active_q, active_d;
   logic [TIMER_W-1:0] cnt_q,    cnt_d;

   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         active_d = 1'b1;
         cnt_d    = TIMER_W'(1);
      end else if (active_q) begin
         if (ack_i || (cnt_q == LIMIT)) begin
            active_d = 1'b0;
         end else begin
            cnt_d = cnt_q + TIMER_W'(1);
         end
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
      end
   end

   assign expired_o = active_q && !ack_i && (cnt_q == LIMIT);

endmodule : lc3_mem_timer

// File: rtl/lc3_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lc3_mem_ctrl
// LC-3 MAR/MDR memory controller. Accepts read/write requests from the
// datapath, runs a request/acknowledge handshake with external memory and
// signals completion with a one-cycle MEM_R pulse.
//
// Build option
//   LC3_MEM_TIMEOUT_EN : when defined, an access that sees no MEM_ACK for
//                        WAIT_TIMEOUT cycles is abandoned through the ERR
//                        state (MDR <= 16'hDEAD on reads, BUS_ERR pulse).
//                        When undefined, the controller waits indefinitely
//                        and BUS_ERR is tied low.
//
// Ports
//   CLK           in   rising-edge clock
//   RESET         in   asynchronous, active-high reset
//   BUS_IN        in   processor bus value
//   LDMAR         in   load MAR from BUS_IN
//   LDMDR[1:0]    in   bit1 load MDR, bit0 source (0 memory, 1 BUS_IN)
//   MEM_RW        in   request a write of MDR to M[MAR]
//   GATE_MDR_SEL  in   drive MDR onto MDR_OUT
//   MDR_OUT       out  MDR when gated, else 0
//   MEM_R         out  one-cycle access-complete pulse
//   MEM_ADDR      out  external address
//   MEM_WDATA     out  external write data
//   MEM_EN        out  external request, held until acknowledged
//   MEM_WE        out  external write strobe (qualified by MEM_EN)
//   MEM_RDATA     in   external read data, valid with MEM_ACK
//   MEM_ACK       in   external completion
//   BUS_ERR       out  one-cycle timeout pulse
// -----------------------------------------------------------------------------
module lc3_mem_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int unsigned WAIT_TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] BUS_IN,
   input  logic        LDMAR,
   input  logic [1:0]  LDMDR,
   input  logic        MEM_RW,
   input  logic        GATE_MDR_SEL,
   output logic [15:0] MDR_OUT,
   output logic        MEM_R,
   output logic [15:0] MEM_ADDR,
   output logic [15:0] MEM_WDATA,
   output logic        MEM_EN,
   output logic        MEM_WE,
   input  logic [15:0] MEM_RDATA,
   input  logic        MEM_ACK,
   output logic        BUS_ERR
);

   mem_state_e  state_q;
   logic [15:0] mar_q,   mar_d;
   logic [15:0] mdr_q;
   logic [15:0] addr_q,  addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        en_q;
   logic        we_q;
   logic        r_q;
   logic        err_q;

   logic        start_wr;
   logic        start_rd;
   logic        expired;

   // Requests are only honoured in IDLE; a write wins over a read.
   // An access launched together with LDMAR / LDMDR=LD_BUS sees the new
   // BUS_IN value rather than the stale register.
   always_comb begin
      start_wr = (state_q == IDLE) && MEM_RW;
      start_rd = (state_q == IDLE) && !MEM_RW && (LDMDR == LD_MEMOUT);
      mar_d    = LDMAR ? BUS_IN : mar_q;
      addr_d   = mar_d;
      wdata_d  = (LDMDR == LD_BUS) ? BUS_IN : mdr_q;
   end

`ifdef LC3_MEM_TIMEOUT_EN
   lc3_mem_timer #(
      .WAIT_TIMEOUT (WAIT_TIMEOUT)
   ) u_timer (
      .CLK       (CLK),
      .RESET     (RESET),
      .start_i   (start_wr || start_rd),
      .ack_i     (MEM_ACK),
      .expired_o (expired)
   );
`else
   assign expired = 1'b0;

   // WAIT_TIMEOUT only matters in the timeout build
   logic unused_wait_timeout;
   assign unused_wait_timeout = (WAIT_TIMEOUT != 0) && expired;
`endif

   // Address and write data are captured when the access starts so they stay
   // stable for the whole handshake even if MAR/MDR are reloaded meanwhile.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         r_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         r_q   <= 1'b0;
         err_q <= 1'b0;
         mar_q <= mar_d;

         // Bus load of MDR; a read capture or error fill below overrides it
         if (LDMDR == LD_BUS) begin
            mdr_q <= BUS_IN;
         end

         case (state_q)
            IDLE: begin
               if (start_wr) begin
                  state_q <= WR;
                  en_q    <= 1'b1;
                  we_q    <= 1'b1;
                  addr_q  <= addr_d;
                  wdata_q <= wdata_d;
               end else if (start_rd) begin
                  state_q <= RD;
                  en_q    <= 1'b1;
                  we_q    <= 1'b0;
                  addr_q  <= addr_d;
                  wdata_q <= wdata_d;
               end
            end

            RD, WR: begin
               if (MEM_ACK) begin
                  if (state_q == RD) begin
                     mdr_q <= MEM_RDATA;
                  end
                  state_q <= DONE;
                  en_q    <= 1'b0;
                  we_q    <= 1'b0;
                  r_q     <= 1'b1;
               end else if (expired) begin
`ifdef LC3_MEM_TIMEOUT_EN
                  if (state_q == RD) begin
                     mdr_q <= ERR_DATA;
                  end
                  state_q <= ERR;
                  en_q    <= 1'b0;
                  we_q    <= 1'b0;
                  r_q     <= 1'b1;
                  err_q   <= 1'b1;
`else
                  state_q <= state_q;
`endif
               end
            end

            DONE: begin
               state_q <= IDLE;
            end

`ifdef LC3_MEM_TIMEOUT_EN
            ERR: begin
               state_q <= IDLE;
            end
`endif

            default: begin
               state_q <= IDLE;
               en_q    <= 1'b0;
               we_q    <= 1'b0;
            end
         endcase
      end
   end

   assign MDR_OUT   = GATE_MDR_SEL ? mdr_q : 16'h0000;
   assign MEM_R     = r_q;
   assign MEM_ADDR  = addr_q;
   assign MEM_WDATA = wdata_q;
   assign MEM_EN    = en_q;
   assign MEM_WE    = we_q;
   assign BUS_ERR   = err_q;

endmodule : lc3_mem_ctrl

// File: tb/tb_lc3_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lc3_mem_ctrl
// Self-checking bench for lc3_mem_ctrl. A transaction-level model tracks the
// access in flight (kind, address, data, wait count) and the architectural
// MAR/MDR; a negedge compare process checks the DUT against it every cycle.
// Directed sequences with literal expectations come first, then randomized
// traffic with a randomly acknowledging memory and occasional resets.
// With LC3_MEM_TIMEOUT_EN defined the DUT is built with WAIT_TIMEOUT=4 and
// the timeout sequences are added.
// -----------------------------------------------------------------------------
module tb_lc3_mem_ctrl;

`ifdef LC3_MEM_TIMEOUT_EN
   localparam int WT    = 4;
   localparam bit TO_EN = 1'b1;
`else
   localparam int WT    = 15;
   localparam bit TO_EN = 1'b0;
`endif

   localparam int P_IDLE   = 0;  // no access in flight
   localparam int P_BUSY   = 1;  // waiting for memory
   localparam int P_FINISH = 2;  // completion pulse cycle

   logic        CLK = 1'b0;
   logic        RESET;
   logic [15:0] BUS_IN;
   logic        LDMAR;
   logic [1:0]  LDMDR;
   logic        MEM_RW;
   logic        GATE_MDR_SEL;
   logic [15:0] MDR_OUT;
   logic        MEM_R;
   logic [15:0] MEM_ADDR;
   logic [15:0] MEM_WDATA;
   logic        MEM_EN;
   logic        MEM_WE;
   logic [15:0] MEM_RDATA;
   logic        MEM_ACK;
   logic        BUS_ERR;

   int n_checks = 0;
   int n_fail   = 0;

   lc3_mem_ctrl #(
      .WAIT_TIMEOUT (WT)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .BUS_IN       (BUS_IN),
      .LDMAR        (LDMAR),
      .LDMDR        (LDMDR),
      .MEM_RW       (MEM_RW),
      .GATE_MDR_SEL (GATE_MDR_SEL),
      .MDR_OUT      (MDR_OUT),
      .MEM_R        (MEM_R),
      .MEM_ADDR     (MEM_ADDR),
      .MEM_WDATA    (MEM_WDATA),
      .MEM_EN       (MEM_EN),
      .MEM_WE       (MEM_WE),
      .MEM_RDATA    (MEM_RDATA),
      .MEM_ACK      (MEM_ACK),
      .BUS_ERR      (BUS_ERR)
   );

   always #5 CLK = ~CLK;

   // ---------------------------------------------------------------- model
   typedef struct {
      int          phase;
      bit          write;
      bit          err;
      int          waited;
      logic [15:0] mar;
      logic [15:0] mdr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.phase  = P_IDLE;
      r.write  = 1'b0;
      r.err    = 1'b0;
      r.waited = 0;
      r.mar    = 16'h0000;
      r.mdr    = 16'h0000;
      r.addr   = 16'h0000;
      r.wdata  = 16'h0000;
      return r;
   endfunction

   // One clock edge of the controller, described as transactions
   function automatic model_t model_step(input model_t cur);
      model_t n = cur;
      if (LDMDR == 2'b11) n.mdr = BUS_IN;
      if (LDMAR) n.mar = BUS_IN;
      case (cur.phase)
         P_IDLE: begin
            if (MEM_RW || LDMDR == 2'b10) begin
               n.phase  = P_BUSY;
               n.write  = MEM_RW;
               n.addr   = LDMAR ? BUS_IN : cur.mar;
               n.wdata  = (LDMDR == 2'b11) ? BUS_IN : cur.mdr;
               n.waited = 0;
            end
         end
         P_BUSY: begin
            n.waited = cur.waited + 1;
            if (MEM_ACK) begin
               if (!cur.write) n.mdr = MEM_RDATA;
               n.phase = P_FINISH;
               n.err   = 1'b0;
            end else if (TO_EN && n.waited == WT) begin
               if (!cur.write) n.mdr = 16'hDEAD;
               n.phase = P_FINISH;
               n.err   = 1'b1;
            end
         end
         default: n.phase = P_IDLE;
      endcase
      return n;
   endfunction

   always @(posedge CLK or posedge RESET) begin
      if (RESET) m <= model_reset();
      else       m <= model_step(m);
   end

   // ---------------------------------------------------------------- checks
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      check("mem_en",  16'(MEM_EN),  16'(m.phase == P_BUSY));
      check("mem_we",  16'(MEM_WE),  16'(m.phase == P_BUSY && m.write));
      check("mem_r",   16'(MEM_R),   16'(m.phase == P_FINISH));
      check("bus_err", 16'(BUS_ERR), 16'(m.phase == P_FINISH && m.err));
      check("mdr_out", MDR_OUT, GATE_MDR_SEL ? m.mdr : 16'h0000);
      if (m.phase == P_BUSY) begin
         check("mem_addr", MEM_ADDR, m.addr);
         if (m.write) check("mem_wdata", MEM_WDATA, m.wdata);
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic drive(input logic [15:0] bus, input logic ldmar, input logic [1:0] ldmdr,
                        input logic rw, input logic gate, input logic ack,
                        input logic [15:0] rdata);
      @(posedge CLK);
      #2;
      BUS_IN       = bus;
      LDMAR        = ldmar;
      LDMDR        = ldmdr;
      MEM_RW       = rw;
      GATE_MDR_SEL = gate;
      MEM_ACK      = ack;
      MEM_RDATA    = rdata;
   endtask

   task automatic settle();
      @(negedge CLK);
      #1;
   endtask

   int en_cycles;
   int r_pulses;

   initial begin
      RESET = 1'b1;
      BUS_IN = '0; LDMAR = 1'b0; LDMDR = 2'b00; MEM_RW = 1'b0;
      GATE_MDR_SEL = 1'b1; MEM_ACK = 1'b0; MEM_RDATA = '0;
      m = model_reset();
      repeat (3) @(posedge CLK);
      settle();
      check("reset_mdr",    MDR_OUT, 16'h0000);
      check("reset_mem_en", 16'(MEM_EN), 16'h0000);
      check("reset_mem_r",  16'(MEM_R), 16'h0000);
      @(posedge CLK);
      #2 RESET = 1'b0;

      // Fetch: MAR<-3000 with read request, ack on first RD cycle
      drive(16'h3000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000);
      settle();
      check("fetch_req_en", 16'(MEM_EN), 16'h0000);
      drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1261);
      settle();
      check("fetch_en",   16'(MEM_EN), 16'h0001);
      check("fetch_addr", MEM_ADDR, 16'h3000);
      check("fetch_r_early", 16'(MEM_R), 16'h0000);
      drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000);
      settle();
      check("fetch_r_pulse", 16'(MEM_R), 16'h0001);
      check("fetch_mdr",     MDR_OUT, 16'h1261);
      drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000);
      settle();
      check("fetch_r_end", 16'(MEM_R), 16'h0000);

      // Write: MAR<-4000, then BEEF via LD_BUS with write request, ack on 5th cycle
      drive(16'h4000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
      drive(16'hBEEF, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0000);
      en_cycles = 0;
      for (int i = 0; i < 5; i++) begin
         drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, (i == 4), 16'h7777);
         settle();
         if (MEM_EN) en_cycles++;
         check("wr_we",    16'(MEM_WE), 16'h0001);
         check("wr_wdata", MEM_WDATA, 16'hBEEF);
         check("wr_addr",  MEM_ADDR, 16'h4000);
      end
      drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000);
      settle();
      check("wr_en_cycles", 16'(en_cycles), 16'd5);
      check("wr_r_pulse",   16'(MEM_R), 16'h0001);
      check("wr_en_drop",   16'(MEM_EN), 16'h0000);
      check("wr_mdr_kept",  MDR_OUT, 16'hBEEF);

      // Busy: second read while in RD and a request during DONE are dropped
      drive(16'h1234, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000);
      en_cycles = 0;
      r_pulses  = 0;
      for (int i = 0; i < 5; i++) begin
         drive(16'h0000, 1'b0, (i == 0 || i == 2) ? 2'b10 : 2'b00, 1'b0, 1'b1,
               (i == 1), 16'h5A5A);
         settle();
         if (MEM_EN) en_cycles++;
         if (MEM_R)  r_pulses++;
      end
      check("busy_en_cycles", 16'(en_cycles), 16'd2);
      check("busy_r_pulses",  16'(r_pulses), 16'd1);
      check("busy_mdr",       MDR_OUT, 16'h5A5A);

      // Reset on the 2nd RD cycle drops MEM_EN at once and clears MDR
      drive(16'h2222, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000);
      drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000);
      drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000);
      check("rst_pre_en", 16'(MEM_EN), 16'h0001);
      RESET = 1'b1;
      #1;
      check("rst_async_en", 16'(MEM_EN), 16'h0000);
      check("rst_mdr",      MDR_OUT, 16'h0000);
      @(posedge CLK);
      #2 RESET = 1'b0;
      drive(16'h6000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000);
      drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0F0F);
      settle();
      check("rst_next_addr", MEM_ADDR, 16'h6000);
      drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000);
      settle();
      check("rst_next_r",   16'(MEM_R), 16'h0001);
      check("rst_next_mdr", MDR_OUT, 16'h0F0F);

`ifdef LC3_MEM_TIMEOUT_EN
      // Read with no ack: ERR after WAIT_TIMEOUT=4 cycles
      drive(16'h7000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000);
         settle();
         check("to_wait_en", 16'(MEM_EN), 16'h0001);
      end
      drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000);
      settle();
      check("to_bus_err", 16'(BUS_ERR), 16'h0001);
      check("to_mem_r",   16'(MEM_R), 16'h0001);
      check("to_mdr",     MDR_OUT, 16'hDEAD);
      // Ack in the 4th wait cycle still counts as success
      drive(16'h7001, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, (i == 3), 16'h1111);
      end
      drive(16'h0000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000);
      settle();
      check("to_late_ack_err", 16'(BUS_ERR), 16'h0000);
      check("to_late_ack_r",   16'(MEM_R), 16'h0001);
      check("to_late_ack_mdr", MDR_OUT, 16'h1111);
`endif

      // Randomized traffic; memory acks only sometimes, occasionally spuriously
      for (int i = 0; i < 4000; i++) begin
         logic       ack;
         logic [1:0] ldmdr;
         ack   = (m.phase == P_BUSY) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         ldmdr = 2'($urandom_range(0, 3));
         drive(16'($urandom), ($urandom_range(0, 3) == 0), ldmdr,
               ($urandom_range(0, 7) == 0), 1'($urandom), ack, 16'($urandom));
         RESET = ($urandom_range(0, 299) == 0);
      end
      @(posedge CLK);
      #2 RESET = 1'b0;
      repeat (3) @(posedge CLK);
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_lc3_mem_ctrl

// File: doc/lc3_mem_ctrl.md
LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 15, giving the maximum cycles to wait for MEM_ACK (timeout build only; range 1..255).
REQ-002 SHALL have port CLK  in  1  system clock; all state is updated on the rising edge.
REQ-003 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port BUS_IN  in  16  processor bus value.
REQ-005 SHALL have port LDMAR  in  1  load MAR from BUS_IN.
REQ-006 SHALL have port LDMDR  in  2  bit1 = load MDR; bit0 = source (0 memory read, 1 BUS_IN).
REQ-007 SHALL have port MEM_RW  in  1  1 = request a write of MDR to M[MAR].
REQ-008 SHALL have port GATE_MDR_SEL  in  1  drive MDR onto MDR_OUT.
REQ-009 SHALL have port MDR_OUT  out  16  MDR when GATE_MDR_SEL=1, else 16'h0000.
REQ-010 SHALL have port MEM_R  out  1  one-cycle access-complete pulse.
REQ-011 SHALL have port MEM_ADDR  out  16  external address.
REQ-012 SHALL have port MEM_WDATA  out  16  external write data.
REQ-013 SHALL have port MEM_EN  out  1  external request, held until acknowledged.
REQ-014 SHALL have port MEM_WE  out  1  external write strobe, qualified by MEM_EN.
REQ-015 SHALL have port MEM_RDATA  in  16  external read data, valid with MEM_ACK.
REQ-016 SHALL have port MEM_ACK  in  1  external completion.
REQ-017 SHALL have port BUS_ERR  out  1  one-cycle timeout pulse.

Function
REQ-018 SHALL implement states IDLE, RD, WR, DONE, plus ERR in the timeout build only.
REQ-019 In IDLE, SHALL start a read when LDMDR=2'b10 (next state RD) or a write when MEM_RW=1 (next state WR); if both are asserted, SHALL start the write.
REQ-020 SHALL load MAR from BUS_IN whenever LDMAR=1; an access started in the same cycle SHALL use BUS_IN as its address.
REQ-021 In RD and WR, SHALL hold MEM_EN=1, MEM_ADDR=MAR, MEM_WDATA=MDR and MEM_WE=(state==WR) stable until MEM_ACK=1.
REQ-022 On MEM_ACK in RD, SHALL load MDR with MEM_RDATA and go to DONE; on MEM_ACK in WR, SHALL go to DONE.
REQ-023 MEM_ACK in the first RD/WR cycle SHALL give a latency of 2 cycles from the request cycle to the MEM_R pulse.
REQ-024 In DONE, SHALL assert MEM_R for exactly one cycle and return to IDLE.
REQ-025 LDMDR=2'b11 SHALL load MDR from BUS_IN in any state, except that a same-cycle MEM_ACK read capture SHALL take priority.
REQ-026 A write requested in the same cycle as LDMDR=2'b11 SHALL write the BUS_IN value.
REQ-027 Requests arriving outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-028 MEM_ACK received in IDLE or DONE SHALL be ignored.

Reset
REQ-029 While RESET=1: state=IDLE, MAR=0, MDR=0, and MEM_EN, MEM_WE, MEM_R, BUS_ERR all 0.
REQ-030 RESET asserted mid-access SHALL drop MEM_EN immediately (asynchronously) and abandon the access with no MDR update.

Configuration
REQ-031 With macro LC3_MEM_TIMEOUT_EN defined: a counter SHALL start on entry to RD/WR; after WAIT_TIMEOUT cycles without MEM_ACK the block SHALL go to ERR.
REQ-032 In ERR, the block SHALL load MDR with 16'hDEAD (read accesses only), pulse BUS_ERR and MEM_R together for one cycle, then return to IDLE.
REQ-033 A MEM_ACK arriving in the same cycle the timeout expires SHALL be treated as success.
REQ-034 With LC3_MEM_TIMEOUT_EN undefined: the block SHALL wait for MEM_ACK indefinitely, BUS_ERR SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-035 Package lc3_mem_pkg SHALL hold the state encoding type, the LDMDR encodings (LD_MEMOUT=2'b10, LD_BUS=2'b11) and the constant ERR_DATA=16'hDEAD.
REQ-036 The timeout counter SHALL be sub-module lc3_mem_timer (start, ack in; expired out), instantiated only under LC3_MEM_TIMEOUT_EN.

Verification
REQ-037 Fetch: BUS_IN=16'h3000 with LDMAR=1, LDMDR=10; memory acks next cycle with 16'h1261 -> MEM_ADDR=3000, MDR=1261, MEM_R pulse 2 cycles after the request; GATE_MDR_SEL=1 gives MDR_OUT=1261.
REQ-038 Write: MAR=16'h4000, LDMDR=11 with BUS_IN=16'hBEEF and MEM_RW=1 -> MEM_WE=1, MEM_WDATA=BEEF, MEM_EN held 5 cycles until a delayed ack, then one MEM_R pulse.
REQ-039 Busy: a second read request issued while in RD -> ignored; exactly one MEM_EN episode and one MEM_R pulse.
REQ-040 Reset mid-read: RESET asserted on the 2nd RD cycle -> MEM_EN=0 in the same cycle; MDR=0; next request starts cleanly from IDLE.
REQ-041 Timeout build, WAIT_TIMEOUT=4, read with no ack -> BUS_ERR and MEM_R pulse together, MDR=16'hDEAD; with ack on cycle 4 -> success and no BUS_ERR.
